ngy_grid_renderer: RTL and testbench



---
 rtl/ngy_video_pkg.sv | 38 +++
 rtl/ngy_video_timing.sv | 69 ++++++
 rtl/ngy_grid_renderer.sv | 137 +++++++++++++
 tb/tb_ngy_grid_renderer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ngy_video_pkg.sv
// Shared constants for the ngy video path.
// Holds the default raster timing (active area, porches, sync widths, totals),
// the cell geometry, the colour constants and small helpers that derive line/frame
// totals from an active size.
package ngy_video_pkg;

  localparam int unsigned CELL_PX    = 8;
  localparam int unsigned CELL_SHIFT = $clog2(CELL_PX);

  localparam int unsigned H_ACTIVE = 320;
  localparam int unsigned H_FP     = 8;
  localparam int unsigned H_SYNC   = 32;
  localparam int unsigned H_BP     = 40;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 240;
  localparam int unsigned V_FP     = 2;
  localparam int unsigned V_SYNC   = 3;
  localparam int unsigned V_BP     = 17;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [23:0] ON_COLOR      = 24'hFFFFFF;
  localparam logic [23:0] OFF_COLOR     = 24'h000000;
  localparam logic [23:0] OUTLINE_COLOR = 24'h404040;
  localparam bit          OUTLINE_EN    = 1'b1;

  // Width of the flat cell index (covers the default 1200-cell grid).
  localparam int unsigned IDX_W = 11;

  function automatic int unsigned h_total(input int unsigned h_active);
    return h_active + H_FP + H_SYNC + H_BP;
  endfunction

  function automatic int unsigned v_total(input int unsigned v_active);
    return v_active + V_FP + V_SYNC + V_BP;
  endfunction

endpackage

// File: rtl/ngy_video_timing.sv
// Raster timing generator for the ngy grid renderer.
// Ports:
//   clk_74a    - system clock, rising edge
//   reset      - synchronous, active-high
//   pix_ce     - pixel clock-enable; counters advance only when high
//   h_cnt      - horizontal pixel counter, 0..HTotal-1
//   v_cnt      - line counter, 0..VTotal-1, steps when h_cnt wraps
//   active     - current position is inside the visible area
//   hs_raw     - horizontal sync window (undelayed)
//   vs_raw     - vertical sync window (undelayed)
//   snap_point - first pixel of vertical blanking (h=0, v=VActive)
module ngy_video_timing
  import ngy_video_pkg::*;
#(
  parameter int unsigned HActive = H_ACTIVE,
  parameter int unsigned VActive = V_ACTIVE,
  localparam int unsigned HTotal  = h_total(HActive),
  localparam int unsigned VTotal  = v_total(VActive),
  localparam int unsigned HCntW   = $clog2(HTotal),
  localparam int unsigned VCntW   = $clog2(VTotal)
) (
  input  logic             clk_74a,
  input  logic             reset,
  input  logic             pix_ce,
  output logic [HCntW-1:0] h_cnt,
  output logic [VCntW-1:0] v_cnt,
  output logic             active,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             snap_point
);

  logic [HCntW-1:0] h_cnt_q, h_cnt_d;
  logic [VCntW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      if (h_cnt_q == HCntW'(HTotal - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VCntW'(VTotal - 1)) ? '0 : v_cnt_q + VCntW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HCntW'(1);
      end
    end
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt = h_cnt_q;
  assign v_cnt = v_cnt_q;

  assign active = (h_cnt_q < HCntW'(HActive)) && (v_cnt_q < VCntW'(VActive));
  assign hs_raw = (h_cnt_q >= HCntW'(HActive + H_FP)) &&
                  (h_cnt_q <  HCntW'(HActive + H_FP + H_SYNC));
  assign vs_raw = (v_cnt_q >= VCntW'(VActive + V_FP)) &&
                  (v_cnt_q <  VCntW'(VActive + V_FP + V_SYNC));
  assign snap_point = (h_cnt_q == '0) && (v_cnt_q == VCntW'(VActive));

endmodule

// File: rtl/ngy_grid_renderer.sv
// Renders the ngy one-bit cell grid as a raster of CELL_PX x CELL_PX blocks.
// The grid is snapshotted once per frame at the start of vertical blanking so that
// grid writes during the visible area never tear. Output is two pix_ce stages behind
// the counters: stage 1 looks up the cell bit, stage 2 picks the colour.
// Ports:
//   clk_74a     - system clock, rising edge
//   reset       - synchronous, active-high; wins over pix_ce
//   pix_ce      - pixel clock-enable; all state holds while low
//   grid_ram    - cell bits, cell (r,c) = grid_ram[r*GRID_COLS+c]
//   freeze      - inhibits the per-frame snapshot
//   vid_rgb     - pixel colour, zero outside the active area
//   vid_de      - active-video qualifier
//   vid_hs      - horizontal sync, active-high
//   vid_vs      - vertical sync, active-high
//   frame_start - single-cycle pulse on the cycle the snapshot is taken
module ngy_grid_renderer
  import ngy_video_pkg::*;
#(
  parameter int unsigned GRID_ROWS = V_ACTIVE / CELL_PX,
  parameter int unsigned GRID_COLS = H_ACTIVE / CELL_PX
) (
  input  logic                             clk_74a,
  input  logic                             reset,
  input  logic                             pix_ce,
  input  logic [0:GRID_ROWS*GRID_COLS-1]   grid_ram,
  input  logic                             freeze,
  output logic [23:0]                      vid_rgb,
  output logic                             vid_de,
  output logic                             vid_hs,
  output logic                             vid_vs,
  output logic                             frame_start
);

  localparam int unsigned Cells    = GRID_ROWS * GRID_COLS;
  localparam int unsigned CellIdxW = (Cells > 1) ? $clog2(Cells) : 1;
  localparam int unsigned HActive  = GRID_COLS * CELL_PX;
  localparam int unsigned VActive  = GRID_ROWS * CELL_PX;
  localparam int unsigned HCntW    = $clog2(h_total(HActive));
  localparam int unsigned VCntW    = $clog2(v_total(VActive));

  logic [HCntW-1:0] h_cnt;
  logic [VCntW-1:0] v_cnt;
  logic             active, hs_raw, vs_raw, snap_point;

  ngy_video_timing #(
    .HActive(HActive),
    .VActive(VActive)
  ) u_timing (
    .clk_74a   (clk_74a),
    .reset     (reset),
    .pix_ce    (pix_ce),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hs_raw    (hs_raw),
    .vs_raw    (vs_raw),
    .snap_point(snap_point)
  );

  // Snapshot
  logic             capture;
  logic [0:Cells-1] snap_q;

  assign capture     = pix_ce && snap_point && !freeze;
  assign frame_start = capture && !reset;

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      snap_q <= '0;
    end else if (capture) begin
      snap_q <= grid_ram;
    end
  end

  // Stage 1: cell lookup
  logic [IDX_W-1:0] col, row, idx;
  logic             cell_bit, cell_edge;

  always_comb begin
    col = IDX_W'(h_cnt >> CELL_SHIFT);
    row = IDX_W'(v_cnt >> CELL_SHIFT);
    // Blanking positions would index past the grid; park them on cell 0.
    idx = active ? IDX_W'(row * IDX_W'(GRID_COLS) + col) : '0;
    cell_bit  = snap_q[idx[CellIdxW-1:0]];
    // Left column and top row of each cell form the outline.
    cell_edge = (h_cnt[CELL_SHIFT-1:0] == '0) || (v_cnt[CELL_SHIFT-1:0] == '0);
  end

  logic s1_active_q, s1_hs_q, s1_vs_q, s1_cell_q, s1_edge_q;

  // Stage 2: colour select
  logic [23:0] rgb_d, rgb_q;
  logic        de_q, hs_q, vs_q;

  always_comb begin
    rgb_d = '0;
    if (s1_active_q) begin
      if (OUTLINE_EN && s1_edge_q) begin
        rgb_d = OUTLINE_COLOR;
      end else if (s1_cell_q) begin
        rgb_d = ON_COLOR;
      end else begin
        rgb_d = OFF_COLOR;
      end
    end
  end

  always_ff @(posedge clk_74a) begin
    if (reset) begin
      s1_active_q <= 1'b0;
      s1_hs_q     <= 1'b0;
      s1_vs_q     <= 1'b0;
      s1_cell_q   <= 1'b0;
      s1_edge_q   <= 1'b0;
      rgb_q       <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
    end else if (pix_ce) begin
      s1_active_q <= active;
      s1_hs_q     <= hs_raw;
      s1_vs_q     <= vs_raw;
      s1_cell_q   <= cell_bit;
      s1_edge_q   <= cell_edge;
      rgb_q       <= rgb_d;
      de_q        <= s1_active_q;
      hs_q        <= s1_hs_q;
      vs_q        <= s1_vs_q;
    end
  end

  assign vid_rgb = rgb_q;
  assign vid_de  = de_q;
  assign vid_hs  = hs_q;
  assign vid_vs  = vs_q;

endmodule

// File: tb/tb_ngy_grid_renderer.sv
module tb_ngy_grid_renderer;

  // Reduced grid (2x6 cells) with the standard porches: 128 pixels x 38 lines.
  localparam int ROWS   = 2;
  localparam int COLS   = 6;
  localparam int CELLS  = ROWS * COLS;
  localparam int HA     = COLS * 8;
  localparam int VA     = ROWS * 8;
  localparam int HT     = HA + 8 + 32 + 40;
  localparam int VT     = VA + 2 + 3 + 17;
  localparam int FRAME  = HT * VT;
  localparam int HS_BEG = HA + 8;
  localparam int HS_END = HA + 8 + 32;
  localparam int VS_BEG = VA + 2;
  localparam int VS_END = VA + 2 + 3;

  logic               clk_74a = 1'b0;
  logic               reset   = 1'b1;
  logic               pix_ce  = 1'b0;
  logic               freeze  = 1'b0;
  logic [0:CELLS-1]   grid_ram = '0;
  logic [23:0]        vid_rgb;
  logic               vid_de, vid_hs, vid_vs, frame_start;

  ngy_grid_renderer #(
    .GRID_ROWS(ROWS),
    .GRID_COLS(COLS)
  ) dut (
    .clk_74a    (clk_74a),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .grid_ram   (grid_ram),
    .freeze     (freeze),
    .vid_rgb    (vid_rgb),
    .vid_de     (vid_de),
    .vid_hs     (vid_hs),
    .vid_vs     (vid_vs),
    .frame_start(frame_start)
  );

  always #5 clk_74a = ~clk_74a;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int stream_bad = 0;
  int cur_h, cur_v, p1_h, p1_v, p2_h, p2_v;
  bit p1_ok, p2_ok;
  bit slow = 1'b0;
  logic [0:CELLS-1] m_snap;
  int fs_cnt = 0, de_cnt = 0, line_de = 0, n_tick = 0;
  int fs_tick_last = 0, fs_tick_prev = 0;
  int fs_hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] m_rgb(input bit ok, input int h, input int v);
    if (!ok || h >= HA || v >= VA) return 24'h0;
    if (h % 8 == 0 || v % 8 == 0) return 24'h404040;
    return m_snap[(v / 8) * COLS + h / 8] ? 24'hFFFFFF : 24'h000000;
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    pix_ce = 1'b1;
    @(posedge clk_74a);
    #1;
    reset  = 1'b0;
    cur_h = 0; cur_v = 0;
    p1_ok = 1'b0; p2_ok = 1'b0;
    m_snap = '0;
    de_cnt = 0; line_de = 0;
  endtask

  // One enabled pixel; in slow mode followed by two disabled cycles that must hold.
  task automatic tick();
    logic        fs_exp, fs_seen;
    logic [23:0] e_rgb;
    logic        e_de, e_hs, e_vs;
    logic [26:0] held;
    pix_ce = 1'b1;
    #1;
    fs_exp  = (cur_h == 0 && cur_v == VA && !freeze);
    fs_seen = (frame_start === 1'b1);
    if (frame_start !== fs_exp) stream_bad++;
    if (fs_exp) m_snap = grid_ram;
    @(posedge clk_74a);
    #1;
    n_tick++;
    if (fs_seen) begin
      fs_cnt++;
      fs_tick_prev = fs_tick_last;
      fs_tick_last = n_tick;
    end
    p2_ok = p1_ok; p2_h = p1_h; p2_v = p1_v;
    p1_ok = 1'b1;  p1_h = cur_h; p1_v = cur_v;
    if (cur_h == HT - 1) begin
      cur_h = 0;
      cur_v = (cur_v == VT - 1) ? 0 : cur_v + 1;
    end else begin
      cur_h++;
    end
    e_rgb = m_rgb(p2_ok, p2_h, p2_v);
    e_de  = p2_ok && p2_h < HA && p2_v < VA;
    e_hs  = p2_ok && p2_h >= HS_BEG && p2_h < HS_END;
    e_vs  = p2_ok && p2_v >= VS_BEG && p2_v < VS_END;
    if (vid_rgb !== e_rgb || vid_de !== e_de || vid_hs !== e_hs || vid_vs !== e_vs) begin
      if (stream_bad == 0)
        $display("first stream diff at x=%0d y=%0d: rgb %h de %b hs %b vs %b, want %h %b %b %b",
                 p2_h, p2_v, vid_rgb, vid_de, vid_hs, vid_vs, e_rgb, e_de, e_hs, e_vs);
      stream_bad++;
    end
    if (p2_ok && p2_h == 0) line_de = 0;
    if (vid_de === 1'b1) begin
      de_cnt++;
      line_de++;
    end
    if (slow) begin
      pix_ce = 1'b0;
      held = {vid_rgb, vid_de, vid_hs, vid_vs};
      repeat (2) begin
        @(posedge clk_74a);
        #1;
        if ({vid_rgb, vid_de, vid_hs, vid_vs} !== held || frame_start !== 1'b0) stream_bad++;
      end
    end
  endtask

  // Advance until the output shows position (x,y); always moves at least one pixel.
  task automatic run_until(input int x, input int y);
    int  n;
    logic hit;
    n = 0;
    do begin
      tick();
      n++;
      hit = p2_ok && p2_h == x && p2_v == y;
    end while (!hit && n < 2 * FRAME);
    if (!hit) check($sformatf("reach_%0d_%0d", x, y), 32'(hit), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk_74a);
    #1;
    do_reset();
    check("rst_rgb", 32'(vid_rgb), 32'h0);
    check("rst_de", 32'(vid_de), 32'd0);
    check("rst_hs", 32'(vid_hs), 32'd0);
    check("rst_vs", 32'(vid_vs), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);

    // RAM bits set now only appear after the first capture.
    grid_ram[0]         = 1'b1;
    grid_ram[CELLS - 1] = 1'b1;

    tick();
    check("lat_de_1", 32'(vid_de), 32'd0);
    tick();
    check("lat_de_2", 32'(vid_de), 32'd1);
    check("f0_px_0_0", 32'(vid_rgb), 32'h404040);
    run_until(1, 1);
    check("f0_px_1_1", 32'(vid_rgb), 32'h000000);
    run_until(HT - 1, 2);
    check("line_de", line_de, HA);
    run_until(HS_BEG - 1, 3);
    check("hs_pre", 32'(vid_hs), 32'd0);
    tick();
    check("hs_rise", 32'(vid_hs), 32'd1);
    run_until(HS_END - 1, 3);
    check("hs_last", 32'(vid_hs), 32'd1);
    tick();
    check("hs_fall", 32'(vid_hs), 32'd0);
    run_until(HT - 1, VS_BEG - 1);
    check("vs_pre", 32'(vid_vs), 32'd0);
    check("fs_once", fs_cnt, 1);
    tick();
    check("vs_rise", 32'(vid_vs), 32'd1);
    run_until(HT - 1, VS_END - 1);
    check("vs_last", 32'(vid_vs), 32'd1);
    tick();
    check("vs_fall", 32'(vid_vs), 32'd0);
    run_until(HT - 1, VT - 1);
    check("frame_de", de_cnt, HA * VA);
    check("stream_f0", stream_bad, 0);

    // Frame 1: captured cells 0 and last are lit
    run_until(0, 1);
    check("f1_outline", 32'(vid_rgb), 32'h404040);
    run_until(1, 1);
    check("f1_px_1_1", 32'(vid_rgb), 32'hFFFFFF);
    run_until(9, 1);
    check("f1_px_9_1", 32'(vid_rgb), 32'h000000);
    run_until(0, 8);
    grid_ram[7] = 1'b1;  // cell (1,1) written mid-frame
    run_until(9, 9);
    check("f1_px_9_9", 32'(vid_rgb), 32'h000000);
    run_until(41, 9);
    check("f1_last_cell", 32'(vid_rgb), 32'hFFFFFF);
    run_until(0, VA + 1);
    check("fs_twice", fs_cnt, 2);
    check("fs_period", fs_tick_last - fs_tick_prev, FRAME);

    run_until(9, 9);
    check("f2_px_9_9", 32'(vid_rgb), 32'hFFFFFF);

    freeze = 1'b1;
    grid_ram[7] = 1'b0;
    fs_hold = fs_cnt;
    run_until(9, 9);
    check("frz_f3", 32'(vid_rgb), 32'hFFFFFF);
    run_until(9, 9);
    check("frz_f4", 32'(vid_rgb), 32'hFFFFFF);
    check("frz_no_fs", fs_cnt, fs_hold);
    freeze = 1'b0;
    run_until(9, 9);
    check("unfrz_f5", 32'(vid_rgb), 32'h000000);
    check("unfrz_fs", fs_cnt, fs_hold + 1);
    check("stream_full", stream_bad, 0);

    // Reset in the middle of a frame
    run_until(20, 10);
    do_reset();
    check("mrst_rgb", 32'(vid_rgb), 32'h0);
    check("mrst_de", 32'(vid_de), 32'd0);
    check("mrst_hs", 32'(vid_hs), 32'd0);
    check("mrst_vs", 32'(vid_vs), 32'd0);
    run_until(1, 1);
    check("mrst_px_1_1", 32'(vid_rgb), 32'h000000);
    run_until(41, 9);
    check("mrst_last_cell", 32'(vid_rgb), 32'h000000);
    run_until(1, 1);
    check("mrst_recap", 32'(vid_rgb), 32'hFFFFFF);
    check("stream_mrst", stream_bad, 0);

    // One enable every third cycle
    slow = 1'b1;
    do_reset();
    run_until(HT - 1, VT - 1);
    check("slow_frame_de", de_cnt, HA * VA);
    run_until(1, 1);
    check("slow_px_1_1", 32'(vid_rgb), 32'hFFFFFF);
    run_until(41, 9);
    check("slow_last_cell", 32'(vid_rgb), 32'hFFFFFF);
    check("stream_slow", stream_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
